// File: rtl/pe_sum_collector_if.sv
// Handshake bundle between the PE-array drain stage and the result writer.
// The slave side is the collector; the master side drives rows in and consumes results.
interface pe_sum_collector_if #(
  parameter int COLS  = 4,
  parameter int SUM_W = 19,
  parameter int DEPTH = 8
);
  logic                      in_valid;
  logic [COLS*SUM_W-1:0]     col_sum;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*SUM_W-1:0]     out_data;
  logic [$clog2(DEPTH):0]    count;
  logic                      overflow;

  modport slave (
    input  in_valid, col_sum, out_ready,
    output out_valid, out_data, count, overflow
  );

  modport master (
    output in_valid, col_sum, out_ready,
    input  out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/pe_sum_collector.sv
// Drain stage for the systolic PE array: deskews the staggered bottom-row column
// sums into one aligned row and queues completed rows for the result writer.
module pe_sum_collector #(
  parameter int COLS  = 4,
  parameter int SUM_W = 19,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  pe_sum_collector_if.slave  bus
);
  localparam int ROW_W = COLS * SUM_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  // vld_q[k] is in_valid delayed k+1 cycles; the top tap marks the aligned row.
  logic [COLS-2:0]  vld_q, vld_d;
  logic [ROW_W-1:0] aligned;

  always_comb begin
    vld_d = (vld_q << 1) | (COLS-1)'(bus.in_valid);
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    if (j == COLS - 1) begin : g_direct
      assign aligned[j*SUM_W +: SUM_W] = bus.col_sum[j*SUM_W +: SUM_W];
    end else begin : g_chain
      localparam int LEN = COLS - 1 - j;
      logic [SUM_W-1:0] chain_q [LEN];
      logic [SUM_W-1:0] chain_d [LEN];

      always_comb begin
        chain_d[0] = bus.col_sum[j*SUM_W +: SUM_W];
        for (int k = 1; k < LEN; k++) chain_d[k] = chain_q[k-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < LEN; k++) chain_q[k] <= '0;
        end else begin
          for (int k = 0; k < LEN; k++) chain_q[k] <= chain_d[k];
        end
      end

      assign aligned[j*SUM_W +: SUM_W] = chain_q[LEN-1];
    end
  end

  logic [ROW_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [ROW_W-1:0] out_data_q, out_data_d;
  logic             push, pop, full, push_acc;

  always_comb begin
    push       = vld_q[COLS-2];
    pop        = (count_q != '0) && bus.out_ready;
    full       = (count_q == CW'(DEPTH));
    push_acc   = push && (!full || pop);
    wr_ptr_d   = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push_acc) - CW'(pop);
    overflow_d = overflow_q || (push && full && !pop);
    // The new head is the incoming row only when the queue is otherwise empty.
    if (push_acc && (rd_ptr_d == wr_ptr_q)) out_data_d = aligned;
    else                                    out_data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_acc) mem_q[wr_ptr_q] <= aligned;
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_pe_sum_collector.sv
// Directed bench for pe_sum_collector: skewed row stimulus, hand-computed
// expected rows, occupancy and overflow per cycle.
module tb_pe_sum_collector;
  localparam int COLS  = 4;
  localparam int SUM_W = 19;
  localparam int DEPTH = 8;
  localparam int ROW_W = COLS * SUM_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pe_sum_collector_if #(.COLS(COLS), .SUM_W(SUM_W), .DEPTH(DEPTH)) bus ();

  pe_sum_collector #(.COLS(COLS), .SUM_W(SUM_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [ROW_W-1:0] hist   [COLS];
  logic             hist_v [COLS];

  task automatic vec_chk(input string tag, input logic [ROW_W-1:0] got,
                         input logic [ROW_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] mk4(input logic [SUM_W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [ROW_W-1:0] mk_aff(input int base);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*SUM_W +: SUM_W] = SUM_W'(base + j);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] mk_all(input int v);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*SUM_W +: SUM_W] = SUM_W'(v);
    return r;
  endfunction

  // Drive one cycle: a row started now shows column j in j cycles; idle columns carry junk.
  task automatic tick(input logic start, input logic [ROW_W-1:0] row, input logic rdy);
    for (int j = COLS - 1; j > 0; j--) begin
      hist[j]   = hist[j-1];
      hist_v[j] = hist_v[j-1];
    end
    hist[0]   = row;
    hist_v[0] = start;
    bus.in_valid  = start;
    bus.out_ready = rdy;
    for (int j = 0; j < COLS; j++)
      bus.col_sum[j*SUM_W +: SUM_W] = hist_v[j] ? hist[j][j*SUM_W +: SUM_W]
                                                : SUM_W'(19'h2AAAA + 3 * j);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, '0, 1'b0);
    reset = 1'b0;
    for (int j = 0; j < COLS; j++) hist_v[j] = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.col_sum   = '0;
    reset         = 1'b1;
    for (int j = 0; j < COLS; j++) begin
      hist[j]   = '0;
      hist_v[j] = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    vec_chk("rst_valid", bus.out_valid, 0);
    vec_chk("rst_count", bus.count, 0);
    vec_chk("rst_ovf", bus.overflow, 0);
    vec_chk("rst_data", bus.out_data, 0);

    // single row started in relative cycle 0
    tick(1'b1, mk4(100, 200, 300, 400), 1'b1);
    for (int i = 1; i <= 5; i++) begin
      vec_chk("single_valid", bus.out_valid, (i == 4));
      vec_chk("single_count", bus.count, (i == 4) ? 1 : 0);
      if (i == 4) vec_chk("single_data", bus.out_data, mk4(100, 200, 300, 400));
      tick(1'b0, '0, 1'b1);
    end

    // back-to-back rows 1..3, column j = 1000*r + j
    tick(1'b1, mk_aff(1000), 1'b1);
    tick(1'b1, mk_aff(2000), 1'b1);
    tick(1'b1, mk_aff(3000), 1'b1);
    for (int i = 3; i <= 7; i++) begin
      vec_chk("b2b_valid", bus.out_valid, (i >= 4 && i <= 6));
      if (i >= 4 && i <= 6) vec_chk("b2b_data", bus.out_data, mk_aff(1000 * (i - 3)));
      tick(1'b0, '0, 1'b1);
    end

    // overflow: nine rows into eight slots with the consumer stalled
    do_reset();
    for (int r = 1; r <= 9; r++) tick(1'b1, mk_all(r), 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    vec_chk("ovf_count11", bus.count, 8);
    vec_chk("ovf_flag11", bus.overflow, 0);
    vec_chk("ovf_head11", bus.out_data, mk_all(1));
    tick(1'b0, '0, 1'b0);
    vec_chk("ovf_count12", bus.count, 8);
    vec_chk("ovf_flag12", bus.overflow, 1);
    for (int i = 0; i <= 8; i++) begin
      vec_chk("ovf_drain_valid", bus.out_valid, (i < 8));
      if (i < 8) vec_chk("ovf_drain_data", bus.out_data, mk_all(i + 1));
      vec_chk("ovf_sticky", bus.overflow, 1);
      tick(1'b0, '0, 1'b1);
    end
    vec_chk("ovf_end_count", bus.count, 0);

    // full with simultaneous push and pop
    do_reset();
    for (int r = 1; r <= 9; r++) tick(1'b1, mk_all(10 + r), 1'b0);
    tick(1'b0, '0, 1'b0);
    vec_chk("pp_count10", bus.count, 7);
    vec_chk("pp_head10", bus.out_data, mk_all(11));
    tick(1'b0, '0, 1'b0);
    vec_chk("pp_count11", bus.count, 8);
    vec_chk("pp_head11", bus.out_data, mk_all(11));
    tick(1'b0, '0, 1'b1);
    vec_chk("pp_count12", bus.count, 8);
    vec_chk("pp_ovf12", bus.overflow, 0);
    for (int i = 0; i <= 8; i++) begin
      vec_chk("pp_drain_valid", bus.out_valid, (i < 8));
      if (i < 8) vec_chk("pp_drain_data", bus.out_data, mk_all(12 + i));
      tick(1'b0, '0, 1'b1);
    end
    vec_chk("pp_ovf_end", bus.overflow, 0);

    // reset with three rows buffered and one in flight
    do_reset();
    tick(1'b1, mk_all(21), 1'b0);
    tick(1'b1, mk_all(22), 1'b0);
    tick(1'b1, mk_all(23), 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b1, mk_all(24), 1'b0);
    tick(1'b0, '0, 1'b0);
    vec_chk("mid_count_pre", bus.count, 3);
    reset = 1'b1;
    tick(1'b1, mk_all(99), 1'b1);
    reset = 1'b0;
    vec_chk("mid_count", bus.count, 0);
    vec_chk("mid_ovf", bus.overflow, 0);
    for (int i = 7; i <= 12; i++) begin
      vec_chk("mid_flush_valid", bus.out_valid, 0);
      tick(1'b0, '0, 1'b1);
    end
    tick(1'b1, mk_all(25), 1'b1);
    for (int i = 14; i <= 18; i++) begin
      vec_chk("mid_new_valid", bus.out_valid, (i == 17));
      if (i == 17) vec_chk("mid_new_data", bus.out_data, mk_all(25));
      tick(1'b0, '0, 1'b1);
    end

    // extreme values pass bit-exact
    tick(1'b1, mk4(19'h7FFFF, 19'h0, 19'h40000, 19'h1), 1'b1);
    for (int i = 1; i <= 5; i++) begin
      vec_chk("ext_valid", bus.out_valid, (i == 4));
      if (i == 4) vec_chk("ext_data", bus.out_data, mk4(19'h7FFFF, 19'h0, 19'h40000, 19'h1));
      tick(1'b0, '0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
